// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared loader state encoding, frame field widths and imem geometry
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR} loader_state_t;
  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
  localparam int COUNT_W = 16;
  localparam int WORDS_W = 14;
  localparam int IMEM_AW = 13;
endpackage

// File: rtl/prog_loader_word_asm.sv
// loader_word_asm: little-endian 4-byte word assembler with running XOR checksum
module loader_word_asm (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        xor_en,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [7:0]  checksum
);
  logic [1:0]  idx;
  logic [23:0] part;
  assign word_ready = shift & (idx == 2'd3);
  assign word = {din, part};
  // shift bytes in from the top so after three bytes part holds {b2,b1,b0}
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx <= '0;
      part <= '0;
      checksum <= '0;
    end else if (clear) begin
      idx <= '0;
      checksum <= '0;
    end else begin
      if (shift | xor_en) checksum <= checksum ^ din;
      if (shift) begin
        idx <= idx + 2'd1;
        part <= {din, part[23:8]};
      end
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream frame loader writing 32-bit words into instruction memory
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          IMEM_DEPTH     = 8192,
  parameter logic [7:0]  HEADER_BYTE    = HEADER_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_error,
  output logic [WORDS_W-1:0] words_loaded
);
  localparam int GAP_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] DEPTH = COUNT_W'(IMEM_DEPTH);
  loader_state_t      state;
  logic [7:0]         cnt_lo;
  logic [COUNT_W-1:0] count;
  logic [GAP_W-1:0]   gap;
  logic               accept, in_frame, start, timed_out, last_word, chk_ok;
  logic [COUNT_W-1:0] count_next;
  logic [WORDS_W-1:0] words_next;
  logic [31:0]        asm_word;
  logic               word_ready;
  logic [7:0]         checksum;
  assign accept     = rx_valid & rx_ready;
  assign in_frame   = state == CNT_LO || state == CNT_HI || state == DATA || state == CHECK;
  assign start      = accept && rx_data == HEADER_BYTE && (state == IDLE || state == DONE || state == ERROR);
  assign timed_out  = TIMEOUT_CYCLES != 0 && in_frame && !accept && gap == GAP_LIMIT;
  assign count_next = {rx_data, cnt_lo};
  assign words_next = words_loaded + 1'b1;
  assign last_word  = COUNT_W'(words_next) == count;
  assign chk_ok     = rx_data == checksum;
  loader_word_asm u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .xor_en    (accept && (state == CNT_LO || state == CNT_HI)),
    .shift     (accept && state == DATA),
    .din       (rx_data),
    .word      (asm_word),
    .word_ready(word_ready),
    .checksum  (checksum)
  );
  // frame FSM: header restart, count capture, word writes, checksum verdict and inter-byte timeout
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rx_ready <= 1'b0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      cpu_hold <= 1'b0;
      load_done <= 1'b0;
      load_error <= 1'b0;
      words_loaded <= '0;
      cnt_lo <= '0;
      count <= '0;
      gap <= '0;
    end else begin
      rx_ready <= 1'b1;
      imem_we <= 1'b0;
      gap <= (in_frame && !accept) ? gap + 1'b1 : '0;
      if (start) begin
        state <= CNT_LO;
        cpu_hold <= 1'b1;
        load_done <= 1'b0;
        load_error <= 1'b0;
        words_loaded <= '0;
      end else if (timed_out) begin
        state <= ERROR;
        load_error <= 1'b1;
      end else if (accept) begin
        case (state)
          CNT_LO: begin
            cnt_lo <= rx_data;
            state <= CNT_HI;
          end
          CNT_HI: begin
            count <= count_next;
            load_error <= count_next > DEPTH;
            state <= count_next > DEPTH ? ERROR : count_next == '0 ? CHECK : DATA;
          end
          DATA:
            if (word_ready) begin
              imem_we <= 1'b1;
              imem_addr <= words_loaded[IMEM_AW-1:0];
              imem_wdata <= asm_word;
              words_loaded <= words_next;
              if (last_word) state <= CHECK;
            end
          CHECK: begin
            state <= chk_ok ? DONE : ERROR;
            cpu_hold <= !chk_ok;
            load_done <= chk_ok;
            load_error <= !chk_ok;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frame stimulus with a write scoreboard and status checks
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset, rx_valid, rx_ready, imem_we, cpu_hold, load_done, load_error;
  logic [7:0]  rx_data;
  logic [12:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [13:0] words_loaded;
  int compared = 0, mismatched = 0;
  logic [44:0] exp_q[$];
  logic [44:0] mon_e;
  logic [31:0] wq[$];

  always #5 clk = ~clk;

  prog_loader #(.IMEM_DEPTH(8192), .HEADER_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input logic d, input logic e, input logic h, input logic [13:0] w);
    check({name, "_done"}, 32'(load_done), 32'(d));
    check({name, "_error"}, 32'(load_error), 32'(e));
    check({name, "_hold"}, 32'(cpu_hold), 32'(h));
    check({name, "_words"}, 32'(words_loaded), 32'(w));
  endtask

  always @(negedge clk)
    if (!reset && imem_we) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(mon_e[44:32]));
        check("write_data", imem_wdata, mon_e[31:0]);
      end
    end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] cnt, input logic [31:0] w[$], input logic [7:0] corrupt, input int gmax);
    logic [7:0] bytes[$];
    logic [7:0] chk;
    bit over;
    over = cnt > 16'd8192;
    chk = cnt[7:0] ^ cnt[15:8];
    bytes = '{8'hA5, cnt[7:0], cnt[15:8]};
    if (!over) begin
      for (int i = 0; i < int'(cnt); i++) begin
        for (int k = 0; k < 4; k++) begin
          bytes.push_back(w[i][8*k +: 8]);
          chk ^= w[i][8*k +: 8];
        end
        exp_q.push_back({13'(i), w[i]});
      end
      bytes.push_back(chk ^ corrupt);
    end
    foreach (bytes[j]) begin
      send(bytes[j]);
      if (gmax > 0) idle(int'($urandom_range(gmax, 0)));
    end
    idle(2);
    check("queue_drained", exp_q.size(), 0);
    if (over) check_status("oversize", 1'b0, 1'b1, 1'b1, 14'd0);
    else if (corrupt != 8'd0) check_status("bad_chk", 1'b0, 1'b1, 1'b1, cnt[13:0]);
    else check_status("good", 1'b1, 1'b0, 1'b0, cnt[13:0]);
  endtask

  initial begin
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(rx_ready), 0);
    check("reset_we", 32'(imem_we), 0);
    check("reset_addr", 32'(imem_addr), 0);
    check("reset_wdata", imem_wdata, 0);
    check_status("reset", 1'b0, 1'b0, 1'b0, 14'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(rx_ready), 1);
    send(8'h00);
    send(8'hFF);
    idle(2);
    check_status("garbage", 1'b0, 1'b0, 1'b0, 14'd0);
    wq = '{32'h15000000, 32'h1900000A};
    frame(16'd2, wq, 8'h00, 0);
    frame(16'd2, wq, 8'h03, 0);
    frame(16'd2, wq, 8'h00, 1);
    frame(16'h2001, wq, 8'h00, 0);
    wq.delete();
    frame(16'd0, wq, 8'h00, 0);
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'hAA);
    idle(10);
    check_status("timeout_early", 1'b0, 1'b0, 1'b1, 14'd0);
    idle(10);
    check_status("timeout", 1'b0, 1'b1, 1'b1, 14'd0);
    send(8'hA5);
    send(8'h02);
    send(8'h00);
    send(8'h15);
    send(8'h00);
    check_status("mid_frame_hold", 1'b0, 1'b0, 1'b1, 14'd0);
    #1 reset = 1'b1;
    #1;
    check("midreset_ready", 32'(rx_ready), 0);
    check("midreset_we", 32'(imem_we), 0);
    check("midreset_addr", 32'(imem_addr), 0);
    check("midreset_wdata", imem_wdata, 0);
    check_status("midreset", 1'b0, 1'b0, 1'b0, 14'd0);
    rx_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    wq = '{32'h15000000, 32'h1900000A};
    frame(16'd2, wq, 8'h00, 0);
    for (int f = 0; f < 20; f++) begin
      int n;
      logic [7:0] bad;
      n = int'($urandom_range(6, 0));
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      bad = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      frame(16'(n), wq, bad, 3);
    end
    idle(4);
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
